// File: rtl/hnoc_port_arbiter.sv
// HNoC output-port arbiter: destination-range filter, round-robin with burst hold,
// one-entry registered output stage. Define HNOC_ARB_STATS_EN to add grant/stall counters.
module hnoc_port_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumReq    = 4,
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned DestMin   = 0,
  parameter int unsigned DestMax   = 15,
  parameter int unsigned MaxBurst  = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [NumReq*DataWidth-1:0] i_req_data,
  input  logic [NumReq-1:0]           i_req_data_valid,
  output logic [NumReq-1:0]           o_req_data_ready,
  output logic [DataWidth-1:0]        o_data,
  output logic                        o_data_valid,
  input  logic                        i_data_ready,
  output logic [NumReq-1:0]           o_grant
`ifdef HNOC_ARB_STATS_EN
  ,
  output logic [NumReq*16-1:0]        o_grant_count,
  output logic [15:0]                 o_stall_count
`endif
);

  localparam int unsigned PtrW   = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned BurstW = 4;

  localparam logic [AddrWidth:0]  DestMinW = (AddrWidth+1)'(DestMin);
  localparam logic [AddrWidth:0]  DestMaxW = (AddrWidth+1)'(DestMax);
  localparam logic [AddrWidth:0]  AddrOne  = (AddrWidth+1)'(1);
  localparam logic [BurstW-1:0]   BurstLim = BurstW'(MaxBurst);
  localparam logic [BurstW-1:0]   BurstOne = BurstW'(1);
  localparam logic [PtrW-1:0]     PtrOne   = PtrW'(1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [DataWidth-1:0] data_q,  data_d;
  logic [NumReq-1:0]    grant_q, grant_d;
  logic [PtrW-1:0]      ptr_q,   ptr_d;
  logic [PtrW-1:0]      last_q,  last_d;
  logic [BurstW-1:0]    burst_q, burst_d;

  logic [NumReq-1:0]    eligible;
  logic [NumReq-1:0]    ready;
  logic [AddrWidth:0]   dest_x;
  logic [PtrW-1:0]      sel;
  logic                 found;
  int unsigned          idx;
  logic                 ld;

`ifdef HNOC_ARB_STATS_EN
  logic [15:0] gcnt_q [NumReq];
  logic [15:0] gcnt_d [NumReq];
  logic [15:0] stall_q, stall_d;
`endif

  // Lower bound tested as dest+1 > DestMin so DestMin=0 is not a constant compare.
  always_comb begin
    eligible = '0;
    dest_x   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      dest_x      = {1'b0, i_req_data[k*DataWidth + (DataWidth-AddrWidth) +: AddrWidth]};
      eligible[k] = i_req_data_valid[k] &&
                    ((dest_x + AddrOne) > DestMinW) &&
                    (dest_x <= DestMaxW);
    end
  end

  // Burst hold on the previous winner first, else rotate from the pointer; a sole
  // eligible requester is always found by the rotating search.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    if (eligible[last_q] && (burst_q < BurstLim)) begin
      sel   = last_q;
      found = 1'b1;
    end
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = (32'(ptr_q) + i) % NumReq;
      if (!found && eligible[idx]) begin
        sel   = PtrW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ld    = i_reset && (|eligible) && ((state_q == ST_EMPTY) || i_data_ready);
    ready = '0;
    if (ld) begin
      ready[sel] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    burst_d = burst_q;
    if (ld) begin
      state_d = ST_FULL;
      data_d  = i_req_data[32'(sel)*DataWidth +: DataWidth];
      grant_d = ready;
      ptr_d   = (32'(sel) == NumReq - 1) ? '0 : sel + PtrOne;
      last_d  = sel;
      if (sel != last_q) begin
        burst_d = BurstOne;
      end else if (burst_q != '1) begin
        burst_d = burst_q + BurstOne;
      end
    end else if ((state_q == ST_FULL) && i_data_ready) begin
      state_d = ST_EMPTY;
      grant_d = '0;
    end
  end

`ifdef HNOC_ARB_STATS_EN
  always_comb begin
    for (int unsigned k = 0; k < NumReq; k++) begin
      gcnt_d[k] = gcnt_q[k];
      if (ld && (32'(sel) == k) && (gcnt_q[k] != 16'hFFFF)) begin
        gcnt_d[k] = gcnt_q[k] + 16'd1;
      end
    end
    stall_d = stall_q;
    if ((state_q == ST_FULL) && !i_data_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      last_q  <= '0;
      burst_q <= '0;
`ifdef HNOC_ARB_STATS_EN
      for (int unsigned k = 0; k < NumReq; k++) begin
        gcnt_q[k] <= '0;
      end
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      burst_q <= burst_d;
`ifdef HNOC_ARB_STATS_EN
      for (int unsigned k = 0; k < NumReq; k++) begin
        gcnt_q[k] <= gcnt_d[k];
      end
      stall_q <= stall_d;
`endif
    end
  end

  assign o_req_data_ready = ready;
  assign o_data           = data_q;
  assign o_data_valid     = (state_q == ST_FULL);
  assign o_grant          = grant_q;

`ifdef HNOC_ARB_STATS_EN
  always_comb begin
    o_grant_count = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      o_grant_count[k*16 +: 16] = gcnt_q[k];
    end
  end
  assign o_stall_count = stall_q;
`endif

endmodule

// File: tb/tb_hnoc_port_arbiter.sv
// Directed bench for hnoc_port_arbiter: instance A (range 4..7, burst 4) and
// instance B (full range, burst 1) share stimulus.
module tb_hnoc_port_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] req_data;
  logic [3:0]   req_valid;
  logic         data_ready;

  logic [3:0]   a_rdy, a_grant, b_rdy, b_grant;
  logic [31:0]  a_data, b_data;
  logic         a_vld, b_vld;
`ifdef HNOC_ARB_STATS_EN
  logic [63:0]  a_gcnt, b_gcnt;
  logic [15:0]  a_stall, b_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hnoc_port_arbiter #(
    .DataWidth(32), .NumReq(4), .AddrWidth(4),
    .DestMin(4), .DestMax(7), .MaxBurst(4)
  ) dut_a (
    .i_clk(clk), .i_reset(rst_n),
    .i_req_data(req_data), .i_req_data_valid(req_valid),
    .o_req_data_ready(a_rdy), .o_data(a_data), .o_data_valid(a_vld),
    .i_data_ready(data_ready), .o_grant(a_grant)
`ifdef HNOC_ARB_STATS_EN
    , .o_grant_count(a_gcnt), .o_stall_count(a_stall)
`endif
  );

  hnoc_port_arbiter #(
    .DataWidth(32), .NumReq(4), .AddrWidth(4),
    .DestMin(0), .DestMax(15), .MaxBurst(1)
  ) dut_b (
    .i_clk(clk), .i_reset(rst_n),
    .i_req_data(req_data), .i_req_data_valid(req_valid),
    .o_req_data_ready(b_rdy), .o_data(b_data), .o_data_valid(b_vld),
    .i_data_ready(data_ready), .o_grant(b_grant)
`ifdef HNOC_ARB_STATS_EN
    , .o_grant_count(b_gcnt), .o_stall_count(b_stall)
`endif
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  vld;
    logic [15:0] dests;
    logic        dr;
    logic [3:0]  rdy;
    logic [3:0]  grant;
    logic        ovld;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] flit(input logic [3:0] dest, input int k);
    return {dest, 24'h0, 4'(k)};
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [15:0] d,
                              input logic dr, input logic [3:0] rdy, input logic [3:0] g,
                              input logic ov);
    vec_t t;
    t.rst_n = r; t.vld = v; t.dests = d; t.dr = dr;
    t.rdy = rdy; t.grant = g; t.ovld = ov;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_flits(input logic [15:0] dests);
    for (int k = 0; k < 4; k++) req_data[k*32 +: 32] = flit(dests[k*4 +: 4], k);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_data;
    vec_t        v;

    // Burst phase: reqs 0 and 2, all dest 5.
    repeat (4) vecs.push_back(mk(1, 4'b0101, 16'h5555, 1, 4'b0001, 4'b0001, 1));
    repeat (4) vecs.push_back(mk(1, 4'b0101, 16'h5555, 1, 4'b0100, 4'b0100, 1));
    vecs.push_back(mk(1, 4'b0101, 16'h5555, 1, 4'b0001, 4'b0001, 1));
    // Sole requester: no burst limit.
    repeat (6) vecs.push_back(mk(1, 4'b0001, 16'h5555, 1, 4'b0001, 4'b0001, 1));
    // Range filter: req1 dest 3 blocked, req2 dest 7 granted, then dest 8 blocked.
    repeat (2) vecs.push_back(mk(1, 4'b0110, 16'h5735, 1, 4'b0100, 4'b0100, 1));
    repeat (2) vecs.push_back(mk(1, 4'b0110, 16'h5835, 1, 4'b0000, 4'b0000, 0));
    // Load into empty while stalled, hold, then drain.
    vecs.push_back(mk(1, 4'b0001, 16'h5555, 0, 4'b0001, 4'b0001, 1));
    vecs.push_back(mk(1, 4'b0011, 16'h5555, 0, 4'b0000, 4'b0001, 1));
    vecs.push_back(mk(1, 4'b0011, 16'h5555, 1, 4'b0001, 4'b0001, 1));
    vecs.push_back(mk(1, 4'b0010, 16'h5555, 1, 4'b0010, 4'b0010, 1));
    vecs.push_back(mk(1, 4'b0000, 16'h5555, 1, 4'b0000, 4'b0000, 0));
    // Load at ptr 2 wraps to req0, then reset while full and stalled.
    vecs.push_back(mk(1, 4'b0001, 16'h5555, 0, 4'b0001, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b1111, 16'h5555, 0, 4'b0000, 4'b0000, 0));
    repeat (2) vecs.push_back(mk(1, 4'b1111, 16'h5555, 1, 4'b0001, 4'b0001, 1));

    // Reset held 3 cycles with everyone valid.
    rst_n = 1'b0; req_valid = 4'b1111; data_ready = 1'b1; set_flits(16'h5555);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("reset a_rdy", 32'(a_rdy), 32'h0);
      check("reset b_rdy", 32'(b_rdy), 32'h0);
      @(posedge clk); #1;
      check("reset a_vld", 32'(a_vld), 32'h0);
      check("reset a_grant", 32'(a_grant), 32'h0);
      check("reset a_data", a_data, 32'h0);
      check("reset b_vld", 32'(b_vld), 32'h0);
    end

    exp_data = 32'h0;
    foreach (vecs[i]) begin
      v = vecs[i];
      rst_n = v.rst_n; req_valid = v.vld; data_ready = v.dr; set_flits(v.dests);
      #1;
      check($sformatf("row%0d a_rdy", i), 32'(a_rdy), 32'(v.rdy));
      if (!v.rst_n) exp_data = 32'h0;
      else for (int k = 0; k < 4; k++) if (v.rdy[k]) exp_data = flit(v.dests[k*4 +: 4], k);
      @(posedge clk); #1;
      check($sformatf("row%0d a_grant", i), 32'(a_grant), 32'(v.grant));
      check($sformatf("row%0d a_vld", i), 32'(a_vld), 32'(v.ovld));
      check($sformatf("row%0d a_data", i), a_data, exp_data);
    end

    // Round robin on B (MaxBurst=1): 0,1,2,3,0,...
    rst_n = 1'b0; @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 4'b1111; data_ready = 1'b1; set_flits(16'h5555);
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("rr%0d b_rdy", i), 32'(b_rdy), 32'(1 << (i % 4)));
      @(posedge clk); #1;
      check($sformatf("rr%0d b_grant", i), 32'(b_grant), 32'(1 << (i % 4)));
      check($sformatf("rr%0d b_data", i), b_data, flit(4'h5, i % 4));
    end

    // Backpressure on B with flit 0xA5000001 from req1.
    rst_n = 1'b0; @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 4'b0010; data_ready = 1'b0;
    req_data[32 +: 32] = 32'hA500_0001;
    #1;
    check("bp load b_rdy", 32'(b_rdy), 32'h2);
    @(posedge clk); #1;
    check("bp load b_data", b_data, 32'hA500_0001);
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp%0d b_rdy", c), 32'(b_rdy), 32'h0);
      @(posedge clk); #1;
      check($sformatf("bp%0d b_data", c), b_data, 32'hA500_0001);
      check($sformatf("bp%0d b_vld", c), 32'(b_vld), 32'h1);
      check($sformatf("bp%0d b_grant", c), 32'(b_grant), 32'h2);
    end
`ifdef HNOC_ARB_STATS_EN
    check("bp b_stall", 32'(b_stall), 32'd5);
    check("bp b_gcnt1", 32'(b_gcnt[16 +: 16]), 32'd1);
`endif

    // Reset while full and stalled.
    rst_n = 1'b0;
    #1;
    check("midrst b_rdy", 32'(b_rdy), 32'h0);
    @(posedge clk); #1;
    check("midrst b_vld", 32'(b_vld), 32'h0);
    check("midrst b_grant", 32'(b_grant), 32'h0);
    check("midrst b_data", b_data, 32'h0);
`ifdef HNOC_ARB_STATS_EN
    check("midrst b_stall", 32'(b_stall), 32'd0);
    check("midrst b_gcnt1", 32'(b_gcnt[16 +: 16]), 32'd0);
`endif
    rst_n = 1'b1; data_ready = 1'b1; set_flits(16'h5555);
    #1;
    check("postrst b_rdy", 32'(b_rdy), 32'h1);
    @(posedge clk); #1;
    check("postrst b_grant", 32'(b_grant), 32'h1);
    check("postrst b_data", b_data, flit(4'h5, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
